// File: rtl/falafel_output_serializer.sv
// Response serializer: drains the alloc-result and free-status FIFOs in round-robin order.
// Each popped word goes out as a two-word response, a header and then the payload.
// Optional build macro FALAFEL_RSP_CNT_EN adds per-source completed-response counters.
// Without the macro, both counter ports are tied to zero.
module falafel_output_serializer #(
  parameter int unsigned       DATA_W        = 64,
  parameter logic [DATA_W-1:0] RSP_ALLOC_HDR = 'h1,
  parameter logic [DATA_W-1:0] RSP_FREE_HDR  = 'h2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alloc_fifo_empty_i,
  output logic              alloc_fifo_read_o,
  input  logic [DATA_W-1:0] alloc_fifo_dout_i,
  input  logic              free_fifo_empty_i,
  output logic              free_fifo_read_o,
  input  logic [DATA_W-1:0] free_fifo_dout_i,
  output logic              rsp_val_o,
  input  logic              rsp_rdy_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [31:0]       alloc_rsp_cnt_o,
  output logic [31:0]       free_rsp_cnt_o
);

  typedef enum logic [1:0] {StIdle, StSendHdr, StSendData} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] payload_q, payload_d;
  logic              src_free_q, src_free_d;   // source of the response in flight
  logic              last_free_q, last_free_d; // source served most recently
  logic              pick_alloc, pick_free;

  // Round-robin pick: on a tie, the source that was not served last wins.
  always_comb begin
    pick_alloc = !alloc_fifo_empty_i && (free_fifo_empty_i || last_free_q);
    pick_free  = !free_fifo_empty_i && !pick_alloc;
  end

  // Next-state, FIFO pops and response outputs; all outputs are forced low during reset.
  always_comb begin
    state_d           = state_q;
    payload_d         = payload_q;
    src_free_d        = src_free_q;
    last_free_d       = last_free_q;
    alloc_fifo_read_o = 1'b0;
    free_fifo_read_o  = 1'b0;
    rsp_val_o         = 1'b0;
    rsp_data_o        = '0;
    case (state_q)
      StIdle: begin
        if (pick_alloc) begin
          alloc_fifo_read_o = 1'b1;
          payload_d         = alloc_fifo_dout_i;
          src_free_d        = 1'b0;
          state_d           = StSendHdr;
        end else if (pick_free) begin
          free_fifo_read_o = 1'b1;
          payload_d        = free_fifo_dout_i;
          src_free_d       = 1'b1;
          state_d          = StSendHdr;
        end
      end
      StSendHdr: begin
        rsp_val_o  = 1'b1;
        rsp_data_o = src_free_q ? RSP_FREE_HDR : RSP_ALLOC_HDR;
        if (rsp_rdy_i) state_d = StSendData;
      end
      StSendData: begin
        rsp_val_o  = 1'b1;
        rsp_data_o = payload_q;
        if (rsp_rdy_i) begin
          state_d     = StIdle;
          last_free_d = src_free_q;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rst_i) begin
      alloc_fifo_read_o = 1'b0;
      free_fifo_read_o  = 1'b0;
      rsp_val_o         = 1'b0;
      rsp_data_o        = '0;
    end
  end

  // State register; reset makes last-served "free" so alloc wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      payload_q   <= '0;
      src_free_q  <= 1'b0;
      last_free_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      payload_q   <= payload_d;
      src_free_q  <= src_free_d;
      last_free_q <= last_free_d;
    end
  end

`ifdef FALAFEL_RSP_CNT_EN
  logic [31:0] alloc_cnt_q, free_cnt_q;
  logic        data_done;

  assign data_done = (state_q == StSendData) && rsp_rdy_i;

  // Count completed responses per source; 32-bit arithmetic wraps naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_cnt_q <= '0;
      free_cnt_q  <= '0;
    end else if (data_done) begin
      if (src_free_q) free_cnt_q  <= free_cnt_q + 32'd1;
      else            alloc_cnt_q <= alloc_cnt_q + 32'd1;
    end
  end

  assign alloc_rsp_cnt_o = rst_i ? '0 : alloc_cnt_q;
  assign free_rsp_cnt_o  = rst_i ? '0 : free_cnt_q;
`else
  assign alloc_rsp_cnt_o = '0;
  assign free_rsp_cnt_o  = '0;
`endif

endmodule

// File: doc/falafel_output_serializer.md
FALAFEL_OUTPUT_SERIALIZER -- requirements
Module: falafel_output_serializer

Interface
REQ-001 Parameter DATA_W, default 64: width of response words and FIFO data.
REQ-002 Parameter RSP_ALLOC_HDR, default 'h1: header word sent before an alloc result.
REQ-003 Parameter RSP_FREE_HDR, default 'h2: header word sent before a free status.
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 alloc_fifo_empty_i  input  1  alloc result FIFO empty.
REQ-007 alloc_fifo_read_o  output  1  pop the alloc result FIFO.
REQ-008 alloc_fifo_dout_i  input  DATA_W  alloc FIFO head word, first-word-fall-through, valid when not empty.
REQ-009 free_fifo_empty_i  input  1  free status FIFO empty.
REQ-010 free_fifo_read_o  output  1  pop the free status FIFO.
REQ-011 free_fifo_dout_i  input  DATA_W  free FIFO head word, first-word-fall-through.
REQ-012 rsp_val_o  output  1  response word valid.
REQ-013 rsp_rdy_i  input  1  consumer ready; word transfers when rsp_val_o and rsp_rdy_i are both high.
REQ-014 rsp_data_o  output  DATA_W  response word.
REQ-015 alloc_rsp_cnt_o  output  32  count of completed alloc responses.
REQ-016 free_rsp_cnt_o  output  32  count of completed free responses.

Function
REQ-017 The FSM SHALL have states IDLE, SEND_HDR and SEND_DATA.
REQ-018 In IDLE, if at least one FIFO is non-empty, the block SHALL select a source, pulse that FIFO's read_o for exactly one cycle, capture its dout into a payload register and a source flag, and move to SEND_HDR.
REQ-019 Arbitration SHALL be round-robin:
- Both FIFOs non-empty: the source not served last wins.
- One FIFO non-empty: that FIFO wins.
REQ-020 In SEND_HDR, rsp_val_o SHALL be 1 and rsp_data_o SHALL be RSP_ALLOC_HDR or RSP_FREE_HDR per the source flag; on transfer the FSM SHALL move to SEND_DATA.
REQ-021 In SEND_DATA, rsp_val_o SHALL be 1 and rsp_data_o SHALL be the payload register; on transfer the FSM SHALL return to IDLE and update last-served to the source flag.
REQ-022 rsp_val_o and rsp_data_o SHALL remain stable while rsp_val_o=1 and rsp_rdy_i=0.
REQ-023 In IDLE, rsp_val_o SHALL be 0 and rsp_data_o SHALL be 0.
REQ-024 At most one read_o SHALL be asserted per cycle, and never in SEND_HDR or SEND_DATA.
REQ-025 Latency: a FIFO going non-empty while in IDLE SHALL yield the header on rsp_val_o in the next cycle; peak throughput SHALL be one response (2 words) per 3 cycles.
REQ-026 The payload register SHALL hold its value through SEND_HDR/SEND_DATA regardless of FIFO activity.
REQ-027 rsp_rdy_i SHALL be ignored while rsp_val_o=0.

Reset
REQ-028 When rst_i=1 at a clock edge, the FSM SHALL enter IDLE, the payload register SHALL be cleared, last-served SHALL be set to free (so alloc wins the first tie), and the counters SHALL be cleared.
REQ-029 While in reset, all outputs SHALL be 0.
REQ-030 Reset during SEND_HDR/SEND_DATA SHALL abandon the response; the popped word is lost and no read is reissued.

Configuration
REQ-031 With FALAFEL_RSP_CNT_EN defined:
- alloc_rsp_cnt_o/free_rsp_cnt_o SHALL increment by 1 on each SEND_DATA transfer of the matching source.
- Both counters SHALL wrap from 'hFFFFFFFF to 0.
REQ-032 Without FALAFEL_RSP_CNT_EN, both counter ports SHALL be constant 0 and no counter flops SHALL be instantiated.

Verification
REQ-033 Alloc FIFO holds 'hA000, rsp_rdy_i=1 -> one alloc read pulse, then 'h1 and 'hA000 on consecutive cycles, then IDLE.
REQ-034 Both FIFOs non-empty after reset, alloc='hA0/'hA1, free='hF0 -> order 'h1,'hA0,'h2,'hF0,'h1,'hA1.
REQ-035 Free FIFO holds 'hF0, rsp_rdy_i low for 5 cycles during SEND_HDR -> 'h2 held stable for 5 cycles, no extra reads, then 'hF0.
REQ-036 rst_i asserted during SEND_DATA -> next cycle rsp_val_o=0, FSM in IDLE, counters 0, and the word is not re-sent.
REQ-037 FALAFEL_RSP_CNT_EN defined, 3 alloc and 2 free responses -> alloc_rsp_cnt_o=3, free_rsp_cnt_o=2; undefined -> both 0.
REQ-038 Both FIFOs empty for 10 cycles -> no read pulses and rsp_val_o=0 throughout.
